rom_reader: RTL and testbench

- Address sequencer and stream front-end for the combinational `rom` block (3-bit addr, 8-bit data).
- On a start command it walks an inclusive address range and drives `rom_addr`.
- It registers each returned word and presents it on a valid/ready output stream, with last and done markers.
- It sits directly upstream of the ROM (drives addr) and downstream of it (consumes data_out).

---
 rtl/rom_reader_pkg.sv | 14 +
 rtl/rom_reader_addr_ctr.sv | 45 ++++
 rtl/rom_reader.sv | 133 +++++++++++++
 tb/tb_rom_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared constants and FSM state encoding for rom_reader and the rom it drives.
package rom_reader_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rom_reader_addr_ctr.sv
// Current/last address registers for rom_reader: loads a range, steps with wrap, flags the final address.
module rom_reader_addr_ctr
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] cur,
    output logic              is_last
);

    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;

    // Increment relies on natural ADDR_W-bit overflow for the wrap to 0.
    always_comb begin
        cur_d  = cur_q;
        last_d = last_q;
        if (load) begin
            cur_d  = start_addr;
            last_d = end_addr;
        end else if (inc) begin
            cur_d = cur_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= '0;
            last_q <= '0;
        end else begin
            cur_q  <= cur_d;
            last_q <= last_d;
        end
    end

    assign cur     = cur_q;
    assign is_last = (cur_q == last_q);

endmodule

// File: rtl/rom_reader.sv
// Walks an inclusive, wrapping ROM address range and streams the words out over valid/ready.
// Optional XOR checksum of streamed words when ROM_READER_CHECKSUM_EN is defined.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              ctr_load, ctr_inc;
    logic [ADDR_W-1:0] cur;
    logic              is_last;

    rom_reader_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load),
        .inc        (ctr_inc),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .cur        (cur),
        .is_last    (is_last)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        ctr_load    = 1'b0;
        ctr_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctr_load = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                out_data_d  = rom_data;
                out_valid_d = 1'b1;
                out_last_d  = is_last;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ctr_inc = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (ctr_load) begin
            checksum_d = '0;
        end else if (out_valid_q && out_ready) begin
            checksum_d = checksum_q ^ out_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign rom_addr  = cur;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader driving a behavioural 8x8 ROM; random ranges and backpressure.
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_addr = '0;
    logic [2:0] end_addr = '0;
    logic       busy;
    logic [2:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       done;
    logic [7:0] checksum;

    logic [7:0] rom_mem [0:7];

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] ck_q [$];

    int errors = 0;
    int checks = 0;

    // ready_mode: 0 always ready, 1 random, 2 stall while the DUT sits on stall_addr
    int         ready_mode = 0;
    logic [2:0] stall_addr = '0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    rom_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .done       (done),
        .checksum   (checksum)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: range length is ((e-s) mod 8)+1, addresses step mod 8.
    task automatic issue(input logic [2:0] s, input logic [2:0] e);
        int n;
        int a;
        logic [7:0] ck;
        n  = ((int'(e) - int'(s) + 8) % 8) + 1;
        ck = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_t x;
            a   = (int'(s) + i) % 8;
            x.a = 3'(a);
            x.d = rom_mem[a];
            x.l = (i == n - 1);
            ck  = ck ^ rom_mem[a];
            sb.push_back(x);
        end
`ifdef ROM_READER_CHECKSUM_EN
        ck_q.push_back(ck);
`else
        ck_q.push_back(8'h00);
`endif
        start      = 1'b1;
        start_addr = s;
        end_addr   = e;
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = 3'($urandom_range(0, 7));
        end_addr   = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy || sb.size() != 0) begin
            chk({name, "_timeout"}, 1, 0);
        end
    endtask

    always begin
        @(posedge clk); #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(busy && rom_addr == stall_addr);
        endcase
    end

    // Monitor: handshakes, stall stability, done pulse and checksum.
    logic       have_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [2:0] prev_addr;
    logic       done_exp = 1'b0;
    logic       busy_low_exp = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            have_prev    = 1'b0;
            done_exp     = 1'b0;
            busy_low_exp = 1'b0;
        end else begin
            if (done_exp || done) begin
                chk("done_pulse", int'(done), int'(done_exp));
            end
            if (done_exp && ck_q.size() != 0) begin
                chk("checksum_at_done", int'(checksum), int'(ck_q.pop_front()));
            end
            if (busy_low_exp) begin
                chk("busy_after_done", int'(busy), 0);
            end
            busy_low_exp = done_exp;
            done_exp     = 1'b0;
            if (have_prev && out_valid) begin
                chk("stall_data", int'(out_data), int'(prev_data));
                chk("stall_last", int'(out_last), int'(prev_last));
                chk("stall_addr", int'(rom_addr), int'(prev_addr));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("word_data", int'(out_data), int'(x.d));
                    chk("word_last", int'(out_last), int'(x.l));
                    chk("word_addr", int'(rom_addr), int'(x.a));
                    done_exp = x.l;
                end
            end
            have_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            prev_addr = rom_addr;
        end
    end

    initial begin
        int n;
        rom_mem[0] = 8'h3A; rom_mem[1] = 8'hC5; rom_mem[2] = 8'h71; rom_mem[3] = 8'h0E;
        rom_mem[4] = 8'h9B; rom_mem[5] = 8'h24; rom_mem[6] = 8'hE8; rom_mem[7] = 8'h56;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_checksum", int'(checksum), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        ready_mode = 0;
        issue(3'd0, 3'd7);
        wait_idle("full_range");
        issue(3'd3, 3'd3);
        wait_idle("single");
        issue(3'd6, 3'd1);
        wait_idle("wrap");

        ready_mode = 2;
        stall_addr = 3'd1;
        issue(3'd0, 3'd3);
        n = 0;
        while (!(out_valid && rom_addr == 3'd1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach", int'(out_valid && rom_addr == 3'd1), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_hold_addr", int'(rom_addr), 1);
            chk("stall_hold_valid", int'(out_valid), 1);
        end
        ready_mode = 0;
        wait_idle("stall");

        ready_mode = 1;
        issue(3'd2, 3'd5);
        repeat (3) @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 3'd7;
        end_addr   = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("start_busy");

        ready_mode = 0;
        issue(3'd4, 3'd5);
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", int'(done), 1);
        start      = 1'b1;
        start_addr = 3'd0;
        end_addr   = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_done_ignored", int'(busy), 0);

        ready_mode = 1;
        for (int k = 0; k < 12; k++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            wait_idle("random");
        end

        ready_mode = 2;
        stall_addr = 3'd2;
        issue(3'd0, 3'd7);
        n = 0;
        while (!(out_valid && rom_addr == 3'd2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach", int'(out_valid && rom_addr == 3'd2), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rom_addr", int'(rom_addr), 0);
        chk("abort_out_data", int'(out_data), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_last", int'(out_last), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_checksum", int'(checksum), 0);
        sb.delete();
        ck_q.delete();
        rst = 1'b0;
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
